// File: rtl/nr_div_pkg.sv
// Shared state encoding and width helpers for the sequential non-restoring divider.
// Used by nr_div_step and nr_div_seq_ctrl.
package nr_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } nr_state_t;

  function automatic int dvw_of(input int nx);
    return nx - 1;
  endfunction

  // One extra bit over the dividend so the partial remainder can go negative.
  function automatic int pw_of(input int nx);
    return 2 * nx - 1;
  endfunction

  function automatic int cw_of(input int nx);
    return (nx > 1) ? $clog2(nx) : 1;
  endfunction

endpackage

// File: rtl/nr_div_step.sv
// One non-restoring add/subtract stage: P -/+ (D << k) depending on the sign of P.
// Purely combinational; the sequencer reuses this single instance every iteration.
module nr_div_step
  import nr_div_pkg::*;
#(
  parameter int NX = 3
) (
  input  logic signed [pw_of(NX)-1:0]  p,
  input  logic        [dvw_of(NX)-1:0] d,
  input  logic        [cw_of(NX)-1:0]  k,
  input  logic                         sign,
  output logic signed [pw_of(NX)-1:0]  p_next,
  output logic                         q_bit
);

  localparam int DVW = dvw_of(NX);
  localparam int PW  = pw_of(NX);

  logic signed [PW-1:0] d_sh;

  // Divisor is zero-extended before the shift so the shifted value stays positive.
  assign d_sh   = {{(PW-DVW){1'b0}}, d} << k;
  assign p_next = sign ? (p + d_sh) : (p - d_sh);
  assign q_bit  = ~p_next[PW-1];

endmodule

// File: rtl/nr_div_seq_ctrl.sv
// Sequential non-restoring unsigned divider with start/done handshake (NX iterations + fix-up).
// Optional macro NRDIV_EARLY_OVF_EN: flag overflow at accept and finish immediately.
module nr_div_seq_ctrl
  import nr_div_pkg::*;
#(
  parameter int NX = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [2*dvw_of(NX)-1:0]       dividend,
  input  logic [dvw_of(NX)-1:0]         divisor,
  output logic                          busy,
  output logic                          done,
  output logic [NX-1:0]                 quo,
  output logic [dvw_of(NX)-1:0]         rem,
  output logic                          err
);

  localparam int DVW = dvw_of(NX);
  localparam int PW  = pw_of(NX);
  localparam int CW  = cw_of(NX);

  nr_state_t            state_reg, state_next;
  logic [DVW-1:0]       d_reg;
  logic signed [PW-1:0] p_reg;
  logic [CW-1:0]        cnt_reg;
  logic [NX-1:0]        quo_reg;
  logic [DVW-1:0]       rem_reg;
  logic                 err_reg;

  logic [CW-1:0]        step_k;
  logic signed [PW-1:0] step_p;
  logic                 step_q;
  logic signed [PW-1:0] fix_p;
  logic [NX-1:0]        k_hot;
  logic                 div_zero;
  logic                 accept_err;

  assign div_zero = (divisor == '0);

`ifdef NRDIV_EARLY_OVF_EN
  logic div_ovf;
  assign div_ovf    = {1'b0, dividend} >= ({{NX{1'b0}}, divisor} << NX);
  assign accept_err = div_zero | div_ovf;
`else
  assign accept_err = div_zero;
`endif

  // FIX reuses the step with k=0; it is only taken when P is negative, i.e. P + D.
  assign step_k = (state_reg == FIX) ? '0 : cnt_reg;
  assign fix_p  = p_reg[PW-1] ? step_p : p_reg;

  nr_div_step #(
    .NX(NX)
  ) u_step (
    .p     (p_reg),
    .d     (d_reg),
    .k     (step_k),
    .sign  (p_reg[PW-1]),
    .p_next(step_p),
    .q_bit (step_q)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NX; gi++) begin : g_khot
      assign k_hot[gi] = (cnt_reg == CW'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
`ifdef NRDIV_EARLY_OVF_EN
          state_next = accept_err ? DONE : ITER;
`else
          state_next = ITER;
`endif
        end
      end
      ITER:    if (cnt_reg == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_reg   <= '0;
      p_reg   <= '0;
      cnt_reg <= '0;
      quo_reg <= '0;
      rem_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            d_reg   <= divisor;
            p_reg   <= {1'b0, dividend};
            cnt_reg <= CW'(NX - 1);
            quo_reg <= '0;
            err_reg <= accept_err;
`ifdef NRDIV_EARLY_OVF_EN
            if (accept_err) begin
              quo_reg <= '1;
              rem_reg <= '0;
            end
`endif
          end
        end
        ITER: begin
          p_reg   <= step_p;
          // quo was cleared on accept, so OR-ing in the current bit is enough.
          quo_reg <= quo_reg | (k_hot & {NX{step_q}});
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        FIX: begin
          p_reg   <= fix_p;
          rem_reg <= fix_p[DVW-1:0];
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign quo  = quo_reg;
  assign rem  = rem_reg;
  assign err  = err_reg;

endmodule
